// File: rtl/vanilla_sb_clear_emulator.sv
`default_nettype none
// ============================================================================
// Module   : vanilla_sb_clear_emulator
// Desc     : Responder model for the vanilla core scoreboard clear path.
//            Accepts issued long-latency ops (rd + latency) into independent
//            int/float in-order queues and emits one-cycle scoreboard clear
//            pulses once each entry's latency has elapsed. Tracks per-register
//            pending masks and a sticky duplicate-issue error flag.
//            Optional macro VANILLA_SB_CLEAR_JITTER_EN adds LFSR-based
//            latency jitter (0..7 extra cycles) to model network variation.
// Revision : 1.0 - initial release
// ============================================================================
module vanilla_sb_clear_emulator #(
    parameter int ELS_P            = 8,
    parameter int LAT_WIDTH_P      = 8,
    parameter int REG_ADDR_WIDTH_P = 5,
    parameter int REG_ELS_P        = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    input  logic                        float_i,
    input  logic [REG_ADDR_WIDTH_P-1:0] rd_i,
    input  logic [LAT_WIDTH_P-1:0]      lat_i,
    output logic                        ready_o,
    output logic                        int_sb_clear_o,
    output logic [REG_ADDR_WIDTH_P-1:0] int_sb_clear_id_o,
    output logic                        float_sb_clear_o,
    output logic [REG_ADDR_WIDTH_P-1:0] float_sb_clear_id_o,
    output logic [REG_ELS_P-1:0]        int_pending_o,
    output logic [REG_ELS_P-1:0]        float_pending_o,
    output logic                        dup_err_o
);

    localparam int                     c_ptr_w   = $clog2(ELS_P);
    localparam logic [c_ptr_w:0]       c_ptr_one = 1;
    localparam logic [LAT_WIDTH_P-1:0] c_lat_one = 1;

    // Per-queue status; index 0 = int queue, index 1 = float queue.
    logic [1:0]                  w_full_q;
    logic [1:0]                  w_clear_q;
    logic [1:0]                  w_dup_q;
    logic [REG_ADDR_WIDTH_P-1:0] w_clear_id_q [2];
    logic [REG_ELS_P-1:0]        w_pending_q  [2];

    logic                   w_accept;
    logic [LAT_WIDTH_P-1:0] w_lat;
    logic [LAT_WIDTH_P-1:0] w_load;
    logic                   r_dup;

    // No bypass: a retire in the same cycle does not free the slot.
    assign ready_o  = float_i ? !w_full_q[1] : !w_full_q[0];
    assign w_accept = v_i && ready_o;

`ifdef VANILLA_SB_CLEAR_JITTER_EN
    logic [15:0]          r_lfsr;
    logic [LAT_WIDTH_P:0] w_lat_sum;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying latency jitter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Effective latency: lat_i plus jitter, saturated to the counter range, floored at 1.
    always_comb begin
        w_lat_sum = {1'b0, lat_i} + {{(LAT_WIDTH_P-2){1'b0}}, r_lfsr[2:0]};
        if (w_lat_sum[LAT_WIDTH_P]) begin
            w_lat = '1;
        end else if (w_lat_sum[LAT_WIDTH_P-1:0] == '0) begin
            w_lat = c_lat_one;
        end else begin
            w_lat = w_lat_sum[LAT_WIDTH_P-1:0];
        end
    end
`else
    // Effective latency: lat_i floored at 1.
    always_comb begin
        w_lat = (lat_i == '0) ? c_lat_one : lat_i;
    end
`endif

    // Counter holds "cycles remaining minus one" after the accept edge, so an
    // entry accepted at edge T reaches zero (and clears) in cycle T+lat.
    assign w_load = w_lat - c_lat_one;

    for (genvar q = 0; q < 2; q++) begin : g_queue
        logic [REG_ADDR_WIDTH_P-1:0] r_rd  [ELS_P];
        logic [LAT_WIDTH_P-1:0]      r_cnt [ELS_P];
        logic [c_ptr_w:0]            r_wptr;
        logic [c_ptr_w:0]            r_rptr;
        logic [REG_ELS_P-1:0]        r_pend;
        logic [REG_ELS_P-1:0]        w_clr_mask;
        logic [REG_ELS_P-1:0]        w_set_mask;
        logic                        w_empty;
        logic                        w_enq;
        logic                        w_clear;
        logic [REG_ADDR_WIDTH_P-1:0] w_clear_id;

        assign w_empty = (r_wptr == r_rptr);
        assign w_enq   = w_accept && (float_i == 1'(q));

        // Head retires when its counter has expired; suppressed in the reset cycle.
        assign w_clear    = !w_empty && !reset_i && (r_cnt[r_rptr[c_ptr_w-1:0]] == '0);
        assign w_clear_id = w_clear ? r_rd[r_rptr[c_ptr_w-1:0]] : '0;

        assign w_full_q[q]     = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                                 (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
        assign w_clear_q[q]    = w_clear;
        assign w_clear_id_q[q] = w_clear_id;
        assign w_pending_q[q]  = r_pend;

        // Queue storage: load on enqueue, otherwise count every counter down to zero.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                for (int i = 0; i < ELS_P; i++) begin
                    r_cnt[i] <= '0;
                    r_rd[i]  <= '0;
                end
            end else begin
                for (int i = 0; i < ELS_P; i++) begin
                    if (w_enq && (r_wptr[c_ptr_w-1:0] == c_ptr_w'(i))) begin
                        r_cnt[i] <= w_load;
                        r_rd[i]  <= rd_i;
                    end else if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - c_lat_one;
                    end
                end
                if (w_enq) begin
                    r_wptr <= r_wptr + c_ptr_one;
                end
                if (w_clear) begin
                    r_rptr <= r_rptr + c_ptr_one;
                end
            end
        end

        // One-hot clear and set masks for this cycle's retire and accept.
        always_comb begin
            w_clr_mask = '0;
            w_set_mask = '0;
            if (w_clear) begin
                w_clr_mask[w_clear_id] = 1'b1;
            end
            if (w_enq) begin
                w_set_mask[rd_i] = 1'b1;
            end
        end

        // Pending mask: clear applied before set so a same-cycle re-issue stays pending.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_pend <= '0;
            end else begin
                r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
            end
        end

        assign w_dup_q[q] = w_enq && r_pend[rd_i] && !w_clr_mask[rd_i];
    end

    // Sticky duplicate-issue flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_dup <= 1'b0;
        end else if (|w_dup_q) begin
            r_dup <= 1'b1;
        end
    end

    assign int_sb_clear_o      = w_clear_q[0];
    assign int_sb_clear_id_o   = w_clear_id_q[0];
    assign float_sb_clear_o    = w_clear_q[1];
    assign float_sb_clear_id_o = w_clear_id_q[1];
    assign int_pending_o       = w_pending_q[0];
    assign float_pending_o     = w_pending_q[1];
    assign dup_err_o           = r_dup;

endmodule
`default_nettype wire

// File: tb/tb_vanilla_sb_clear_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vanilla_sb_clear_emulator
// Desc     : Self-checking bench for vanilla_sb_clear_emulator. A queue-based
//            reference model tracks outstanding ops by absolute due cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vanilla_sb_clear_emulator;

    localparam int ELS = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        float_i;
    logic [4:0]  rd_i;
    logic [7:0]  lat_i;
    logic        ready_o;
    logic        int_sb_clear_o;
    logic [4:0]  int_sb_clear_id_o;
    logic        float_sb_clear_o;
    logic [4:0]  float_sb_clear_id_o;
    logic [31:0] int_pending_o;
    logic [31:0] float_pending_o;
    logic        dup_err_o;

    vanilla_sb_clear_emulator dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .v_i                 (v_i),
        .float_i             (float_i),
        .rd_i                (rd_i),
        .lat_i               (lat_i),
        .ready_o             (ready_o),
        .int_sb_clear_o      (int_sb_clear_o),
        .int_sb_clear_id_o   (int_sb_clear_id_o),
        .float_sb_clear_o    (float_sb_clear_o),
        .float_sb_clear_id_o (float_sb_clear_id_o),
        .int_pending_o       (int_pending_o),
        .float_pending_o     (float_pending_o),
        .dup_err_o           (dup_err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [77:0] dut_vec;
    assign dut_vec = {ready_o, int_sb_clear_o, int_sb_clear_id_o, float_sb_clear_o,
                      float_sb_clear_id_o, int_pending_o, float_pending_o, dup_err_o};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outstanding ops with absolute due cycle.
    typedef struct {
        logic [4:0] rd;
        int         due;
    } ent_t;

    ent_t        iq[$];
    ent_t        fq[$];
    logic [31:0] m_pend_i = '0;
    logic [31:0] m_pend_f = '0;
    logic        m_dup    = 1'b0;
    int          cyc      = 0;

    function automatic logic [77:0] model_exp();
        logic       ci, cf, rdy;
        logic [4:0] ii, fi;
        ci  = (iq.size() > 0) && (iq[0].due <= cyc);
        cf  = (fq.size() > 0) && (fq[0].due <= cyc);
        ii  = ci ? iq[0].rd : 5'd0;
        fi  = cf ? fq[0].rd : 5'd0;
        rdy = float_i ? (fq.size() < ELS) : (iq.size() < ELS);
        return {rdy, ci, ii, cf, fi, m_pend_i, m_pend_f, m_dup};
    endfunction

    task automatic model_edge();
        logic ci, cf, acc;
        int   le;
        ent_t e;
        if (reset_i) begin
            iq.delete();
            fq.delete();
            m_pend_i = '0;
            m_pend_f = '0;
            m_dup    = 1'b0;
        end else begin
            ci  = (iq.size() > 0) && (iq[0].due <= cyc);
            cf  = (fq.size() > 0) && (fq[0].due <= cyc);
            acc = v_i && (float_i ? (fq.size() < ELS) : (iq.size() < ELS));
            if (ci) begin
                m_pend_i[iq[0].rd] = 1'b0;
                void'(iq.pop_front());
            end
            if (cf) begin
                m_pend_f[fq[0].rd] = 1'b0;
                void'(fq.pop_front());
            end
            if (acc) begin
                le    = (lat_i == 8'd0) ? 1 : int'(lat_i);
                e.rd  = rd_i;
                e.due = cyc + le;
                if (float_i) begin
                    if (m_pend_f[rd_i]) m_dup = 1'b1;
                    m_pend_f[rd_i] = 1'b1;
                    fq.push_back(e);
                end else begin
                    if (m_pend_i[rd_i]) m_dup = 1'b1;
                    m_pend_i[rd_i] = 1'b1;
                    iq.push_back(e);
                end
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic v, input logic f, input logic [4:0] rd, input logic [7:0] lat);
        v_i     = v;
        float_i = f;
        rd_i    = rd;
        lat_i   = lat;
        @(negedge clk_i);
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_idle(input int max_cycles);
        int i;
        logic [77:0] exp_v;
        i = 0;
        while ((iq.size() > 0 || fq.size() > 0) && i < max_cycles) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            exp_v = model_exp();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL idle_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            advance();
            i++;
        end
        n_checks++;
        if (iq.size() > 0 || fq.size() > 0) begin
            n_fail++;
            $display("FAIL idle_drain_timeout got=%0d/%0d entries left exp=0", iq.size(), fq.size());
        end
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        advance();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            advance();
        end
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [77:0] exp_v;
        do_reset();
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        exp_v = {1'b1, 77'd0};
        n_checks++;
        if (dut_vec !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_v);
        end
        advance();
    endtask

    task automatic test_single();
        int issue_c, clr_c, n_clr;
        logic [77:0] exp_v;
        drive(1'b1, 1'b0, 5'd5, 8'd10);
        issue_c = cyc;
        advance();
        n_clr = 0;
        clr_c = -1;
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            exp_v = model_exp();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL single_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            if (int_sb_clear_o === 1'b1) begin
                n_clr++;
                clr_c = cyc;
            end
            advance();
        end
        n_checks++;
        if (n_clr != 1 || clr_c != issue_c + 10) begin
            n_fail++;
            $display("FAIL single_timing got=%0d pulses at +%0d exp=1 at +10", n_clr, clr_c - issue_c);
        end
    endtask

    task automatic test_in_order();
        int c_first, c_clr[$];
        logic [4:0] ids[$];
        logic [77:0] exp_v;
        drive(1'b1, 1'b0, 5'd3, 8'd20);
        c_first = cyc;
        advance();
        drive(1'b1, 1'b0, 5'd4, 8'd2);
        advance();
        for (int i = 0; i < 25; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            exp_v = model_exp();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL inorder_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            if (int_sb_clear_o === 1'b1) begin
                c_clr.push_back(cyc);
                ids.push_back(int_sb_clear_id_o);
            end
            advance();
        end
        n_checks++;
        if (c_clr.size() != 2) begin
            n_fail++;
            $display("FAIL inorder_count got=%0d exp=2", c_clr.size());
        end else begin
            n_checks++;
            if (c_clr[0] != c_first + 20 || c_clr[1] != c_first + 21 || ids[0] != 5'd3 || ids[1] != 5'd4) begin
                n_fail++;
                $display("FAIL inorder_seq got=rd%0d@+%0d rd%0d@+%0d exp=rd3@+20 rd4@+21",
                         ids[0], c_clr[0] - c_first, ids[1], c_clr[1] - c_first);
            end
        end
        run_idle(50);
    endtask

    task automatic test_full();
        logic seen;
        logic [77:0] exp_v;
        for (int i = 0; i < ELS; i++) begin
            drive(1'b1, 1'b0, 5'(i), 8'd50);
            exp_v = model_exp();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL full_fill_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            advance();
        end
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_int_ready got=%b exp=0", ready_o);
        end
        float_i = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_float_ready got=%b exp=1", ready_o);
        end
        float_i = 1'b0;
        #1;
        advance();
        // Issue into the full queue: must be dropped silently.
        drive(1'b1, 1'b0, 5'd10, 8'd1);
        exp_v = model_exp();
        n_checks++;
        if (dut_vec !== exp_v) begin
            n_fail++;
            $display("FAIL full_drop_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
        end
        advance();
        seen = 1'b0;
        for (int i = 0; i < 70 && !seen; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            exp_v = model_exp();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL full_wait_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            if (int_sb_clear_o === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_no_bypass got=%b exp=0", ready_o);
                end
            end
            advance();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL full_first_clear_timeout got=none exp=clear");
        end
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        n_checks++;
        if (ready_o !== 1'b1 || int_pending_o[10] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after_clear got=ready%b pend10=%b exp=ready1 pend10=0", ready_o, int_pending_o[10]);
        end
        advance();
        run_idle(100);
    endtask

    task automatic test_same_cycle();
        int n_both, n_i, n_f;
        logic [77:0] exp_v;
        drive(1'b1, 1'b1, 5'd7, 8'd6);
        advance();
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        advance();
        drive(1'b1, 1'b0, 5'd7, 8'd4);
        advance();
        n_both = 0; n_i = 0; n_f = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            exp_v = model_exp();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL same_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            if (int_sb_clear_o === 1'b1) n_i++;
            if (float_sb_clear_o === 1'b1) n_f++;
            if (int_sb_clear_o === 1'b1 && float_sb_clear_o === 1'b1 &&
                int_sb_clear_id_o === 5'd7 && float_sb_clear_id_o === 5'd7) n_both++;
            advance();
        end
        n_checks++;
        if (n_both != 1 || n_i != 1 || n_f != 1) begin
            n_fail++;
            $display("FAIL same_cycle_clear got=both%0d int%0d float%0d exp=1/1/1", n_both, n_i, n_f);
        end
        run_idle(20);
    endtask

    task automatic test_dup();
        logic [77:0] exp_v;
        do_reset();
        drive(1'b1, 1'b0, 5'd9, 8'd30);
        advance();
        drive(1'b1, 1'b0, 5'd9, 8'd30);
        advance();
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        n_checks++;
        if (dup_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_set got=%b exp=1", dup_err_o);
        end
        advance();
        run_idle(60);
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        n_checks++;
        if (dup_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_sticky got=%b exp=1", dup_err_o);
        end
        advance();
        do_reset();
        drive(1'b1, 1'b0, 5'd9, 8'd5);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            advance();
        end
        // Re-issue rd 9 in its own clear cycle.
        drive(1'b1, 1'b0, 5'd9, 8'd5);
        n_checks++;
        if (int_sb_clear_o !== 1'b1 || int_sb_clear_id_o !== 5'd9) begin
            n_fail++;
            $display("FAIL dup_clear_cycle got=%b/%0d exp=1/9", int_sb_clear_o, int_sb_clear_id_o);
        end
        advance();
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        exp_v = model_exp();
        n_checks++;
        if (dup_err_o !== 1'b0 || int_pending_o[9] !== 1'b1 || dut_vec !== exp_v) begin
            n_fail++;
            $display("FAIL dup_same_cycle got=dup%b pend9=%b vec=%h exp=dup0 pend9=1 vec=%h",
                     dup_err_o, int_pending_o[9], dut_vec, exp_v);
        end
        advance();
        run_idle(20);
    endtask

    task automatic test_reset_mid();
        int n_clr;
        logic [77:0] exp_v;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'(i % 2), 5'(11 + i), 8'd5);
            advance();
        end
        // Int head is due exactly in this reset cycle.
        reset_i = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 8'd0);
        n_checks++;
        if ({int_sb_clear_o, float_sb_clear_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL resetmid_gate got=%b%b exp=00", int_sb_clear_o, float_sb_clear_o);
        end
        advance();
        reset_i = 1'b0;
        n_clr = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0);
            exp_v = {1'b1, 77'd0};
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL resetmid_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            if (int_sb_clear_o === 1'b1 || float_sb_clear_o === 1'b1) n_clr++;
            advance();
        end
        n_checks++;
        if (n_clr != 0) begin
            n_fail++;
            $display("FAIL resetmid_clears got=%0d exp=0", n_clr);
        end
    endtask

    task automatic test_random();
        logic [77:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 8'($urandom_range(0, 15)));
            exp_v = model_exp();
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_fail++;
                $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_v);
            end
            advance();
        end
        run_idle(300);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        float_i = 1'b0;
        rd_i    = '0;
        lat_i   = '0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_single();
        test_in_order();
        test_full();
        test_same_cycle();
        test_dup();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
